// File: rtl/snake_pkg.sv
// Shared snake-game definitions: heading encodings, keypad scan codes and key decode.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_RIGHT = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  localparam logic [4:0] KEY_LEFT  = 5'h0C;
  localparam logic [4:0] KEY_RIGHT = 5'h0E;
  localparam logic [4:0] KEY_UP    = 5'h09;
  localparam logic [4:0] KEY_DOWN  = 5'h11;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } keyDec_t;

  function automatic keyDec_t decodeKey(input logic [4:0] code);
    keyDec_t d;
    d.valid = 1'b1;
    d.dir   = DIR_UP;
    case (code)
      KEY_LEFT:  d.dir = DIR_LEFT;
      KEY_RIGHT: d.dir = DIR_RIGHT;
      KEY_UP:    d.dir = DIR_UP;
      KEY_DOWN:  d.dir = DIR_DOWN;
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Two-entry heading FIFO; push and pop may happen on the same edge.
module dir_fifo
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  dir_t       pushDir,
  input  logic       pop,
  output dir_t       head,
  output dir_t       tail,
  output logic [1:0] count
);

  dir_t       slot0, slot1;
  logic       doPush, doPop;
  logic [1:0] remaining;

  // Guards keep the count inside 0..2 even if a caller misbehaves.
  assign doPush = push & (count != 2'd2);
  assign doPop  = pop & (count != 2'd0);

  always_comb begin
    remaining = count;
    if (doPop) remaining = count - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot0 <= DIR_UP;
      slot1 <= DIR_UP;
      count <= 2'd0;
    end else begin
      if (doPop) slot0 <= slot1;
      if (doPush) begin
        if (remaining == 2'd0) slot0 <= pushDir;
        else                   slot1 <= pushDir;
      end
      count <= count + {1'b0, doPush} - {1'b0, doPop};
    end
  end

  assign head = slot0;
  assign tail = (count == 2'd2) ? slot1 : slot0;

endmodule

// File: rtl/move_scheduler.sv
// Snake move scheduler: edge-sampled key decode into a 2-deep heading queue,
// applied one heading per move tick.
module move_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] keyCode,
  input  logic       keyReady,
  input  logic       enable,
  output logic [1:0] direction,
  output logic       moveTick,
  output logic [1:0] queueCount,
  output logic       dropped
);

  localparam int         CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          prevReady;
  dir_t          dirReg, qHead, qTail, refDir;
  keyDec_t       dec;
  logic          sample, hit, reject, push, wrap, pop;

  assign dec    = decodeKey(keyCode);
  assign sample = keyReady & ~prevReady;
  assign refDir = (queueCount != 2'd0) ? qTail : dirReg;
  assign hit    = sample & dec.valid;
  // Same or opposite heading share bit 1 of the encoding.
  assign reject = hit & ((queueCount == 2'd2) | (dec.dir[1] == refDir[1]));
  assign push   = hit & ~reject;
  assign wrap   = enable & (cnt == LAST);
  assign pop    = wrap & (queueCount != 2'd0);

  dir_fifo uFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pushDir(dec.dir),
    .pop    (pop),
    .head   (qHead),
    .tail   (qTail),
    .count  (queueCount)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      prevReady <= 1'b0;
      dirReg    <= DIR_UP;
      moveTick  <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      prevReady <= keyReady;
      dropped   <= reject;
      moveTick  <= wrap;
      if (enable) cnt <= wrap ? '0 : cnt + 1'b1;
      if (pop) dirReg <= qHead;
    end
  end

  assign direction = dirReg;

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clock cycles per snake move tick (legal range 2 or more).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 keyCode  input  5  keypad scan code.
REQ-005 keyReady  input  1  keypad valid level; a new key is signalled by a 0->1 transition.
REQ-006 enable  input  1  game running; when low, ticks are paused.
REQ-007 direction  output  2  applied heading: UP=00, DOWN=01, RIGHT=10, LEFT=11.
REQ-008 moveTick  output  1  one-cycle pulse per move step.
REQ-009 queueCount  output  2  number of pending headings, 0..2.
REQ-010 dropped  output  1  one-cycle pulse when a decoded key is rejected.

Function
REQ-011 Key decode SHALL be: 0x0C->LEFT, 0x0E->RIGHT, 0x09->UP, 0x11->DOWN; all other codes SHALL be ignored, with no push and no dropped pulse.
REQ-012 A key SHALL be sampled only in the cycle where keyReady=1 and the registered previous keyReady=0; a held keyReady SHALL yield exactly one sample.
REQ-013 Reference heading SHALL be the queue tail when queueCount>0, otherwise the current direction.
REQ-014 A decoded key equal to the reference heading, or opposite to it (codes differ only in bit 0), SHALL be dropped.
REQ-015 A decoded key SHALL be dropped when queueCount=2.
REQ-016 Any other decoded key SHALL be pushed onto the tail of a 2-entry FIFO.
REQ-017 A dropped key SHALL pulse dropped high for exactly the cycle following the sample.
REQ-018 While enable=1, the counter SHALL count 0..TICK_DIV-1 and wrap to 0.
REQ-019 On the wrap edge, moveTick SHALL go high for one cycle.
REQ-020 On that same edge, if queueCount>0 the head SHALL be popped into direction; direction is therefore already updated in the moveTick=1 cycle.
REQ-021 While enable=0, the counter SHALL hold, moveTick SHALL stay 0, and key acceptance SHALL continue.
REQ-022 Push and pop on the same edge SHALL both occur, and queueCount SHALL be unchanged.
REQ-023 A key pushed into an empty queue on a wrap edge SHALL NOT be applied until the next tick.
REQ-024 queueCount SHALL never exceed 2 or underflow.
REQ-025 The reversal check for a same-edge push SHALL use the pre-edge reference heading.

Reset
REQ-026 On reset=1 at a clock edge, the following SHALL take their reset values: direction=UP, counter=0, queue empty, queueCount=0, moveTick=0, dropped=0, previous keyReady=0.
REQ-027 Reset SHALL override any simultaneous key sample or tick, including mid-operation with a non-empty queue.
REQ-028 Reset SHALL take priority over all other conditions.

Structure
REQ-029 A shared package snake_pkg SHALL hold the direction encodings and the four key-code constants; the decoder in this block SHALL use them.
REQ-030 The 2-entry FIFO SHALL be a sub-module dir_fifo with push/pop/head/tail/count, supporting simultaneous push and pop.
REQ-031 The tick counter width SHALL be the ceiling of log2(TICK_DIV).

Verification (TICK_DIV=4)
REQ-032 Reset, then enable=1 for 12 cycles with no keys -> moveTick high every 4th cycle, direction=UP throughout.
REQ-033 Key 0x0C, then 0x11, each a single keyReady pulse, between ticks -> queueCount=2; next tick direction=LEFT; following tick direction=DOWN.
REQ-034 With direction=UP, key 0x11 -> dropped pulses once, queueCount stays 0.
REQ-035 Queue holding RIGHT then UP, key 0x0C -> dropped because full; key 0x0C held high for 10 cycles is sampled once only.
REQ-036 enable=0 for 20 cycles while a key is pushed -> no moveTick and direction unchanged; the first tick after enable=1 applies the key.
REQ-037 Assert reset with queueCount=2 and direction=LEFT -> next cycle direction=UP, queueCount=0, moveTick=0.
